// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: byte-stream input and key-event output bundle of the set-2 scancode decoder
// Ports (slave = decoder view):
//   received/value/error  in   receive-stage strobe, byte, sticky parity error
//   keyRead               in   consumer pops the head entry
//   keyValid/keyCode/keyExt/keyRelease  out  FIFO head entry
//   shiftHeld/ctrlHeld/altHeld          out  modifier held state
//   overflow/linkError                  out  sticky drop flag, registered error
interface ps2_scancode_decoder_if;
    logic       received;
    logic [7:0] value;
    logic       error;
    logic       keyRead;
    logic       keyValid;
    logic [7:0] keyCode;
    logic       keyExt;
    logic       keyRelease;
    logic       shiftHeld;
    logic       ctrlHeld;
    logic       altHeld;
    logic       overflow;
    logic       linkError;
    modport master (
        output received, value, error, keyRead,
        input  keyValid, keyCode, keyExt, keyRelease, shiftHeld, ctrlHeld, altHeld, overflow, linkError
    );
    modport slave (
        input  received, value, error, keyRead,
        output keyValid, keyCode, keyExt, keyRelease, shiftHeld, ctrlHeld, altHeld, overflow, linkError
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: folds PS/2 set-2 prefix sequences into key events, queues them, tracks modifiers
// Ports:
//   slowClk  in  system clock (shared with the PS/2 receive stage)
//   reset    in  asynchronous active-low reset
//   bus      slave modport of ps2_scancode_decoder_if (byte input, event FIFO head, modifier/status flags)
module ps2_scancode_decoder #(
    parameter int DEPTH = 4
) (
    input logic             slowClk,
    input logic             reset,
    ps2_scancode_decoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, PAUSE} state_t;
    state_t      state, state_nx;
    logic [2:0]  skip, skip_nx;
    logic        push, push_rel, push_ext;
    logic [7:0]  b, push_code;
    logic        is_pre, is_shift, is_noise;
    logic [9:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        full, empty, pop, wr;
    logic [9:0]  head;
    logic        lshift, rshift, ctrl_p, ctrl_e, alt_p, alt_e, overflow, link_error;
    assign b         = bus.value;
    assign is_pre    = b == 8'hE0 || b == 8'hF0 || b == 8'hE1;
    assign is_shift  = b == 8'h12 || b == 8'h59;
    assign is_noise  = b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF;
    // The pause sequence reports itself as a single extended E1 event
    assign push_code = state == PAUSE ? 8'hE1 : b;
    always_comb begin
        state_nx = state;
        skip_nx  = skip;
        push     = 1'b0;
        push_rel = 1'b0;
        push_ext = 1'b0;
        if (bus.error)
            state_nx = IDLE;
        else if (bus.received)
            case (state)
                IDLE: begin
                    state_nx = b == 8'hE0 ? EXT : b == 8'hF0 ? BRK : b == 8'hE1 ? PAUSE : IDLE;
                    skip_nx  = b == 8'hE1 ? 3'd7 : skip;
                    push     = !is_pre && !is_noise;
                end
                EXT: begin
                    state_nx = b == 8'hF0 ? EXTBRK : b == 8'hE0 ? EXT : IDLE;
                    push     = b != 8'hF0 && b != 8'hE0 && !is_shift;
                    push_ext = 1'b1;
                end
                BRK: begin
                    state_nx = IDLE;
                    push     = !is_pre;
                    push_rel = 1'b1;
                end
                EXTBRK: begin
                    state_nx = IDLE;
                    push     = !is_pre && !is_shift;
                    push_rel = 1'b1;
                    push_ext = 1'b1;
                end
                PAUSE: begin
                    skip_nx  = skip - 3'd1;
                    state_nx = skip == 3'd1 ? IDLE : PAUSE;
                    push     = skip == 3'd1;
                    push_ext = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
    end
    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign pop   = bus.keyRead && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign wr    = push && (!full || pop);
    always_ff @(posedge slowClk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            skip       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            link_error <= 1'b0;
            lshift     <= 1'b0;
            rshift     <= 1'b0;
            ctrl_p     <= 1'b0;
            ctrl_e     <= 1'b0;
            alt_p      <= 1'b0;
            alt_e      <= 1'b0;
        end else begin
            state      <= state_nx;
            skip       <= skip_nx;
            link_error <= bus.error;
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(pop);
            if (push && full && !pop) overflow <= 1'b1;
            // Modifiers follow every decoded event, even one dropped for overflow
            if (push && !push_ext && push_code == 8'h12) lshift <= !push_rel;
            if (push && !push_ext && push_code == 8'h59) rshift <= !push_rel;
            if (push && !push_ext && push_code == 8'h14) ctrl_p <= !push_rel;
            if (push && push_ext && push_code == 8'h14) ctrl_e <= !push_rel;
            if (push && !push_ext && push_code == 8'h11) alt_p <= !push_rel;
            if (push && push_ext && push_code == 8'h11) alt_e <= !push_rel;
        end
    end
    always_ff @(posedge slowClk)
        if (wr) mem[wr_ptr] <= {push_rel, push_ext, push_code};
    assign head           = mem[rd_ptr];
    assign bus.keyValid   = !empty;
    assign bus.keyCode    = empty ? 8'h00 : head[7:0];
    assign bus.keyExt     = !empty && head[8];
    assign bus.keyRelease = !empty && head[9];
    assign bus.shiftHeld  = lshift || rshift;
    assign bus.ctrlHeld   = ctrl_p || ctrl_e;
    assign bus.altHeld    = alt_p || alt_e;
    assign bus.overflow   = overflow;
    assign bus.linkError  = link_error;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed bench with an event-level reference model of the scancode decoder
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 4;
    logic slowClk = 1'b0;
    logic reset = 1'b0;
    ps2_scancode_decoder_if bus();
    ps2_scancode_decoder #(.DEPTH(DEPTH)) dut (.slowClk(slowClk), .reset(reset), .bus(bus));
    always #5 slowClk = ~slowClk;
    int checks = 0;
    int passed = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    function automatic logic [15:0] outs();
        return {bus.keyValid, bus.keyRelease, bus.keyExt, bus.keyCode,
                bus.shiftHeld, bus.ctrlHeld, bus.altHeld, bus.overflow, bus.linkError};
    endfunction
    // Reference model: prefix flags, a queue of {rel,ext,code} events, a held-key table indexed by {ext,code}
    logic [9:0] mq[$];
    bit m_e0, m_f0, m_ovf, m_link;
    int m_pause;
    bit held [512];
    logic [9:0] m_head;
    function automatic bit pre(input logic [7:0] v);
        return v == 8'hE0 || v == 8'hF0 || v == 8'hE1;
    endfunction
    function automatic bit shf(input logic [7:0] v);
        return v == 8'h12 || v == 8'h59;
    endfunction
    function automatic bit noise(input logic [7:0] v);
        return v == 8'hAA || v == 8'hFA || v == 8'hEE || v == 8'hFE || v == 8'h00 || v == 8'hFF;
    endfunction
    task automatic model_step();
        bit ev = 0;
        logic [9:0] e = '0;
        logic [7:0] v = bus.value;
        if (bus.error) begin
            m_e0 = 0; m_f0 = 0; m_pause = 0;
        end else if (bus.received) begin
            if (m_pause > 0) begin
                m_pause--;
                if (m_pause == 0) begin ev = 1; e = {2'b01, 8'hE1}; end
            end else if (m_f0) begin
                if (!(pre(v) || (m_e0 && shf(v)))) begin ev = 1; e = {1'b1, m_e0, v}; end
                m_e0 = 0; m_f0 = 0;
            end else if (m_e0) begin
                if (v == 8'hF0) m_f0 = 1;
                else if (v != 8'hE0) begin
                    m_e0 = 0;
                    if (!shf(v)) begin ev = 1; e = {2'b01, v}; end
                end
            end else if (v == 8'hE0) m_e0 = 1;
            else if (v == 8'hF0) m_f0 = 1;
            else if (v == 8'hE1) m_pause = 7;
            else if (!noise(v)) begin ev = 1; e = {2'b00, v}; end
        end
        if (bus.keyRead && mq.size() > 0) void'(mq.pop_front());
        if (ev) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else m_ovf = 1;
            held[e[8:0]] = !e[9];
        end
        m_link = bus.error;
    endtask
    always @(posedge slowClk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_e0 = 0; m_f0 = 0; m_pause = 0; m_ovf = 0; m_link = 0;
            foreach (held[i]) held[i] = 0;
        end else model_step();
    end
    always @(negedge slowClk) begin
        if (reset) begin
            m_head = mq.size() != 0 ? mq[0] : '0;
            check("cycle", outs(), {mq.size() != 0, m_head,
                  held[9'h012] | held[9'h059], held[9'h014] | held[9'h114],
                  held[9'h011] | held[9'h111], m_ovf, m_link});
        end
    end
    task automatic send(input logic [7:0] v);
        @(negedge slowClk);
        bus.received = 1'b1;
        bus.value = v;
        @(negedge slowClk);
        bus.received = 1'b0;
    endtask
    task automatic pop_one();
        @(negedge slowClk);
        bus.keyRead = 1'b1;
        @(negedge slowClk);
        bus.keyRead = 1'b0;
    endtask
    task automatic drain();
        for (int i = 0; i < 2 * DEPTH; i++) if (bus.keyValid) pop_one();
        check("drained", bus.keyValid, 0);
    endtask
    task automatic head(input string name, input logic [9:0] exp);
        check(name, {bus.keyValid, bus.keyRelease, bus.keyExt, bus.keyCode}, {1'b1, exp});
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        logic [7:0] makes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        bus.received = 0; bus.value = 0; bus.error = 0; bus.keyRead = 0;
        repeat (3) @(negedge slowClk);
        check("reset_outputs", outs(), 0);
        reset = 1'b1;
        send(8'h1C);
        head("make_1c", {2'b00, 8'h1C});
        pop_one();
        check("popped_empty", bus.keyValid, 0);
        send(8'hF0);
        check("f0_alone", bus.keyValid, 0);
        send(8'h1C);
        head("break_1c", {2'b10, 8'h1C});
        pop_one();
        send(8'hE0);
        send(8'hF0);
        check("e0f0_alone", bus.keyValid, 0);
        send(8'h75);
        head("extbreak_75", {2'b11, 8'h75});
        pop_one();
        send(8'h12);
        check("shift_make", bus.shiftHeld, 1);
        pop_one();
        send(8'hE0);
        send(8'h12);
        check("fake_shift", {bus.keyValid, bus.shiftHeld}, 2'b01);
        send(8'hF0);
        send(8'h12);
        check("shift_break", bus.shiftHeld, 0);
        drain();
        foreach (pause_seq[i]) send(pause_seq[i]);
        head("pause_event", {2'b01, 8'hE1});
        pop_one();
        check("pause_single", bus.keyValid, 0);
        send(8'h1C);
        head("after_pause", {2'b00, 8'h1C});
        pop_one();
        send(8'h14);
        send(8'hE0);
        send(8'h11);
        check("ctrl_alt_make", {bus.ctrlHeld, bus.altHeld}, 2'b11);
        drain();
        send(8'hE0); send(8'hF0); send(8'h14);
        check("ctrl_plain_still", bus.ctrlHeld, 1);
        send(8'hF0); send(8'h14);
        send(8'hE0); send(8'hF0); send(8'h11);
        check("ctrl_alt_break", {bus.ctrlHeld, bus.altHeld}, 2'b00);
        drain();
        foreach (makes[i]) send(makes[i]);
        check("overflow", {bus.overflow, bus.keyValid, bus.keyCode}, {2'b11, 8'h15});
        @(negedge slowClk);
        bus.keyRead = 1'b1; bus.received = 1'b1; bus.value = 8'h35;
        @(negedge slowClk);
        bus.keyRead = 1'b0; bus.received = 1'b0;
        head("push_pop_full", {2'b00, 8'h1D});
        repeat (3) pop_one();
        head("order_kept", {2'b00, 8'h35});
        drain();
        @(negedge slowClk);
        bus.error = 1'b1;
        send(8'h1C);
        check("error_drop", {bus.keyValid, bus.linkError}, 2'b01);
        bus.error = 1'b0;
        @(negedge slowClk);
        check("error_clear", bus.linkError, 0);
        send(8'h14);
        send(8'h15);
        send(8'hE0);
        @(negedge slowClk);
        #3 reset = 1'b0;
        #1 check("async_reset", outs(), 0);
        @(negedge slowClk);
        reset = 1'b1;
        send(8'h75);
        head("post_reset", {2'b00, 8'h75});
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
